program_loader: RTL and testbench

- Write-side master for the shared instruction RAM; the counterpart of the fetch path, which only reads.
- Accepts a stream of 32-bit instruction words over a valid/ready handshake and writes them to consecutive RAM addresses from a base address.
- Optionally reads the region back and checks it against a running sum.
- Holds the fetch unit and program counter inactive via cpu_hold while it owns the RAM bus.

---
 rtl/program_loader.sv | 199 +++++++++++++++++++
 tb/tb_program_loader.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// program_loader: write-side master for the shared instruction RAM. Streams
// instruction words from a valid/ready source into consecutive addresses,
// optionally reads the region back and compares running sums, and holds the
// CPU fetch path off the bus while it owns the RAM.
module program_loader #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int VERIFY     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] word_count,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  mem_rw,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  verify_ok,
    output logic                  error
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_VERIFY,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] ptr, ptr_nxt;
    logic [ADDR_WIDTH-1:0] remaining, remaining_nxt;
    logic [ADDR_WIDTH-1:0] base_q, base_q_nxt;
    logic [ADDR_WIDTH-1:0] count_q, count_q_nxt;
    logic [DATA_WIDTH-1:0] sum_w, sum_w_nxt;
    logic [DATA_WIDTH-1:0] sum_r, sum_r_nxt;
    logic [DATA_WIDTH-1:0] sum_r_acc;
    // addr_rd: mem_address carries a readback address this cycle.
    // data_rd: mem_rdata carries the data for last cycle's readback address.
    logic                  addr_rd, addr_rd_nxt;
    logic                  data_rd, data_rd_nxt;
    logic                  in_ready_nxt;
    logic                  mem_rw_nxt;
    logic [ADDR_WIDTH-1:0] mem_address_nxt;
    logic [DATA_WIDTH-1:0] mem_wdata_nxt;
    logic                  verify_ok_nxt;
    logic                  error_nxt;
    logic                  last_word;

    // Read data is only folded into the sum when it belongs to a readback address.
    assign sum_r_acc = sum_r + (data_rd ? mem_rdata : '0);
    assign last_word = (remaining == ADDR_WIDTH'(1));

    // Next-state and next-output logic for the load/verify sequence.
    always_comb begin
        // NOTE: every variable gets a blocking default before the case so no
        // path leaves one unassigned; otherwise synthesis would infer a latch.
        state_nxt       = state;
        ptr_nxt         = ptr;
        remaining_nxt   = remaining;
        base_q_nxt      = base_q;
        count_q_nxt     = count_q;
        sum_w_nxt       = sum_w;
        sum_r_nxt       = sum_r;
        addr_rd_nxt     = 1'b0;
        data_rd_nxt     = addr_rd;
        in_ready_nxt    = 1'b0;
        mem_rw_nxt      = 1'b0;
        mem_address_nxt = mem_address;
        mem_wdata_nxt   = mem_wdata;
        verify_ok_nxt   = verify_ok;
        error_nxt       = error;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    verify_ok_nxt = 1'b0;
                    error_nxt     = 1'b0;
                    if (word_count != '0) begin
                        state_nxt     = ST_LOAD;
                        ptr_nxt       = base_addr;
                        remaining_nxt = word_count;
                        base_q_nxt    = base_addr;
                        count_q_nxt   = word_count;
                        sum_w_nxt     = '0;
                        sum_r_nxt     = '0;
                        in_ready_nxt  = 1'b1;
                    end else begin
                        state_nxt     = ST_DONE;
                        verify_ok_nxt = 1'b1;
                    end
                end
            end

            ST_LOAD: begin
                in_ready_nxt = in_ready;
                if (in_valid && in_ready) begin
                    mem_rw_nxt      = 1'b1;
                    mem_address_nxt = ptr;
                    mem_wdata_nxt   = in_data;
                    ptr_nxt         = ptr + ADDR_WIDTH'(1);
                    remaining_nxt   = remaining - ADDR_WIDTH'(1);
                    sum_w_nxt       = sum_w + in_data;
                    if (last_word) begin
                        in_ready_nxt = 1'b0;
                        if (VERIFY != 0) begin
                            state_nxt     = ST_VERIFY;
                            ptr_nxt       = base_q;
                            remaining_nxt = count_q;
                        end else begin
                            state_nxt     = ST_DONE;
                            verify_ok_nxt = 1'b1;
                        end
                    end
                end
            end

            ST_VERIFY: begin
                sum_r_nxt = sum_r_acc;
                if (remaining != '0) begin
                    mem_address_nxt = ptr;
                    ptr_nxt         = ptr + ADDR_WIDTH'(1);
                    remaining_nxt   = remaining - ADDR_WIDTH'(1);
                    addr_rd_nxt     = 1'b1;
                end else begin
                    state_nxt = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                sum_r_nxt     = sum_r_acc;
                verify_ok_nxt = (sum_r_acc == sum_w);
                error_nxt     = (sum_r_acc != sum_w);
                state_nxt     = ST_DONE;
            end

            ST_DONE: begin
                state_nxt = ST_IDLE;
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset wins over any pending transfer.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (reset) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            remaining   <= '0;
            base_q      <= '0;
            count_q     <= '0;
            sum_w       <= '0;
            sum_r       <= '0;
            addr_rd     <= 1'b0;
            data_rd     <= 1'b0;
            in_ready    <= 1'b0;
            mem_rw      <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
            busy        <= 1'b0;
            cpu_hold    <= 1'b0;
            done        <= 1'b0;
            verify_ok   <= 1'b0;
            error       <= 1'b0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            remaining   <= remaining_nxt;
            base_q      <= base_q_nxt;
            count_q     <= count_q_nxt;
            sum_w       <= sum_w_nxt;
            sum_r       <= sum_r_nxt;
            addr_rd     <= addr_rd_nxt;
            data_rd     <= data_rd_nxt;
            in_ready    <= in_ready_nxt;
            mem_rw      <= mem_rw_nxt;
            mem_address <= mem_address_nxt;
            mem_wdata   <= mem_wdata_nxt;
            busy        <= (state_nxt != ST_IDLE);
            cpu_hold    <= (state_nxt != ST_IDLE);
            done        <= (state_nxt == ST_DONE);
            verify_ok   <= verify_ok_nxt;
            error       <= error_nxt;
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: randomized loads against a word-list reference model and
// a synchronous-read RAM model; checks strobes, readback order, flags and RAM.
module tb_program_loader;
    localparam int AW = 16;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] word_count;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          mem_rw;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          busy;
    logic          cpu_hold;
    logic          done;
    logic          verify_ok;
    logic          error;

    always #5 clk = ~clk;

    program_loader #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .VERIFY    (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mem_rw     (mem_rw),
        .mem_address(mem_address),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .verify_ok  (verify_ok),
        .error      (error)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Load context, written only by the stimulus process.
    int            wr_base     = 0;
    int            exp_count   = 0;
    bit            corrupt_en  = 1'b0;
    logic [AW-1:0] corrupt_addr = '0;
    int            hits_at_arm = 0;
    logic [DW-1:0] src [0:15];

    // Observation logs, written only by the monitor.
    logic [AW-1:0] wlog_addr[$];
    logic [DW-1:0] wlog_data[$];
    logic [AW-1:0] rlog[$];
    int            total_writes = 0;
    int            done_total   = 0;
    bit            prev_rd      = 1'b0;
    logic [AW-1:0] prev_rd_addr = '0;

    // RAM model: synchronous write and read, optional one-shot read corruption.
    logic [DW-1:0] ram [0:(1<<AW)-1] = '{default: '0};
    int            corrupt_hits = 0;

    always @(posedge clk) begin
        if (mem_rw) ram[mem_address] <= mem_wdata;
        if (corrupt_en && corrupt_hits == hits_at_arm && busy && !mem_rw
            && (total_writes - wr_base) == exp_count && mem_address == corrupt_addr) begin
            mem_rdata    <= ram[mem_address] ^ DW'(1);
            corrupt_hits <= corrupt_hits + 1;
        end else begin
            mem_rdata <= ram[mem_address];
        end
    end

    // Monitor on the falling edge: write strobes, done pulses, readback addresses.
    always @(negedge clk) begin
        if (mem_rw) begin
            wlog_addr.push_back(mem_address);
            wlog_data.push_back(mem_wdata);
            total_writes++;
        end
        if (done) done_total++;
        if (busy && !mem_rw && (total_writes - wr_base) == exp_count) begin
            if (!(prev_rd && prev_rd_addr == mem_address)) rlog.push_back(mem_address);
            prev_rd      = 1'b1;
            prev_rd_addr = mem_address;
        end else begin
            prev_rd = 1'b0;
        end
    end

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) src[i] = $urandom;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " flags"}, 64'({in_ready, mem_rw, busy, cpu_hold, done, verify_ok, error}), 64'(0));
        check({tag, " mem_address"}, 64'(mem_address), 64'(0));
        check({tag, " mem_wdata"}, 64'(mem_wdata), 64'(0));
    endtask

    // One complete load; the expected result is the word list laid at base..base+n-1.
    task automatic run_load(input string name, input logic [AW-1:0] base, input int n,
                            input bit stall2, input bit rand_stall, input bit busy_start,
                            input bit corrupt);
        int            idx;
        int            stalls;
        int            budget;
        int            w0;
        int            r0;
        int            d0;
        int            h0;
        bit            acc;
        logic [AW-1:0] ea;
        wr_base      = total_writes;
        exp_count    = n;
        w0           = wlog_addr.size();
        r0           = rlog.size();
        d0           = done_total;
        h0           = corrupt_hits;
        hits_at_arm  = corrupt_hits;
        corrupt_addr = base + AW'(1);
        corrupt_en   = corrupt;

        @(posedge clk); #1;
        start      = 1'b1;
        base_addr  = base;
        word_count = AW'(n);
        @(posedge clk); #1;
        start      = 1'b0;
        base_addr  = AW'($urandom);
        word_count = AW'($urandom);
        check({name, " busy after start"}, 64'({busy, cpu_hold}), 64'(2'b11));
        check({name, " flags cleared"}, 64'({verify_ok, error}), 64'(0));

        idx    = 0;
        stalls = 0;
        budget = 0;
        while (idx < n && budget < 400) begin
            in_data  = src[idx];
            in_valid = 1'b1;
            if (stall2 && idx == 2 && stalls < 3) begin
                in_valid = 1'b0;
                stalls++;
            end
            if (rand_stall && $urandom_range(0, 2) == 0) in_valid = 1'b0;
            if (busy_start) begin
                start      = (idx == 1);
                base_addr  = 16'h7000;
                word_count = 16'd3;
            end
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
            budget++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        check({name, " words accepted"}, 64'(idx), 64'(n));

        budget = 0;
        while (done_total == d0 && budget < 300) begin
            @(posedge clk); #1;
            budget++;
        end
        repeat (3) @(posedge clk);
        #1;
        check({name, " done pulses"}, 64'(done_total - d0), 64'(1));
        check({name, " idle after done"}, 64'({busy, cpu_hold, in_ready, mem_rw}), 64'(0));
        check({name, " verify_ok"}, 64'(verify_ok), 64'(!corrupt));
        check({name, " error"}, 64'(error), 64'(corrupt));
        if (corrupt) check({name, " corruption injected"}, 64'(corrupt_hits - h0), 64'(1));
        check({name, " strobe count"}, 64'(wlog_addr.size() - w0), 64'(n));
        check({name, " readback count"}, 64'(rlog.size() - r0), 64'(n));
        for (int i = 0; i < n; i++) begin
            ea = base + AW'(i);
            if (w0 + i < wlog_addr.size()) begin
                check({name, " write addr"}, 64'(wlog_addr[w0 + i]), 64'(ea));
                check({name, " write data"}, 64'(wlog_data[w0 + i]), 64'(src[i]));
            end
            if (r0 + i < rlog.size()) check({name, " read addr"}, 64'(rlog[r0 + i]), 64'(ea));
            check({name, " ram"}, 64'(ram[ea]), 64'(src[i]));
        end
        corrupt_en = 1'b0;
    endtask

    // Zero-length load: done the cycle after start, verify_ok set, no strobe.
    task automatic zero_count();
        int w0;
        w0        = total_writes;
        wr_base   = total_writes;
        exp_count = 0;
        @(posedge clk); #1;
        start      = 1'b1;
        base_addr  = 16'h1234;
        word_count = '0;
        @(posedge clk); #1;
        start = 1'b0;
        check("zero done", 64'(done), 64'(1));
        check("zero verify_ok", 64'({verify_ok, error}), 64'(2'b10));
        check("zero busy in done", 64'(busy), 64'(1));
        @(posedge clk); #1;
        check("zero done ends", 64'({done, busy, cpu_hold}), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        check("zero no strobe", 64'(total_writes - w0), 64'(0));
    endtask

    // Reset lands on the edge that would accept word 3; earlier writes must survive.
    task automatic reset_mid_load();
        int idx;
        int budget;
        bit acc;
        fill_random(6);
        wr_base   = total_writes;
        exp_count = 6;
        @(posedge clk); #1;
        start      = 1'b1;
        base_addr  = 16'h0200;
        word_count = 16'd6;
        @(posedge clk); #1;
        start  = 1'b0;
        idx    = 0;
        budget = 0;
        while (idx < 2 && budget < 50) begin
            in_data  = src[idx];
            in_valid = 1'b1;
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
            budget++;
        end
        check("rst two accepted", 64'(idx), 64'(2));
        in_data  = src[2];
        in_valid = 1'b1;
        reset    = 1'b1;
        @(posedge clk); #1;
        check_all_zero("rst outputs");
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("rst stays idle", 64'({busy, in_ready, mem_rw}), 64'(0));
        in_valid = 1'b0;
        check("rst write count", 64'(total_writes - wr_base), 64'(2));
        check("rst ram word0", 64'(ram[16'h0200]), 64'(src[0]));
        check("rst ram word1", 64'(ram[16'h0201]), 64'(src[1]));
        check("rst ram word2 untouched", 64'(ram[16'h0202]), 64'(0));
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        in_valid   = 1'b0;
        base_addr  = '0;
        word_count = '0;
        in_data    = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;

        src[0] = 32'h11111111;
        src[1] = 32'h22222222;
        src[2] = 32'h33333333;
        src[3] = 32'h44444444;
        run_load("basic", 16'h0010, 4, 1'b0, 1'b0, 1'b0, 1'b0);
        run_load("stall", 16'h0010, 4, 1'b1, 1'b0, 1'b0, 1'b0);

        fill_random(4);
        run_load("wrap", 16'hFFFE, 4, 1'b0, 1'b0, 1'b0, 1'b0);

        fill_random(4);
        run_load("corrupt", 16'h0100, 4, 1'b0, 1'b0, 1'b0, 1'b1);

        zero_count();

        fill_random(5);
        run_load("busy_start", 16'h0300, 5, 1'b0, 1'b1, 1'b1, 1'b0);

        reset_mid_load();

        fill_random(8);
        run_load("after_reset", 16'h0400, 8, 1'b0, 1'b1, 1'b0, 1'b0);

        for (int k = 0; k < 4; k++) begin
            fill_random(12);
            run_load("random", AW'($urandom), int'($urandom_range(1, 12)), 1'b0, 1'b1, 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
